// File: rtl/alu_exec_pkg.sv
// Shared types and decode helpers for the integer execute stage.
// Covers op encoding, aluOp/funct7 constants and the FSM state type.
package alu_exec_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_ILL
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADDR   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} exec_state_e;

    function automatic alu_ctrl_e base_op(input logic [2:0] f3, input logic alt);
        alu_ctrl_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_ctrl_e muldiv_op(input logic [2:0] f3);
        alu_ctrl_e op;
        case (f3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction

    // I-type only honours funct7[5] for the arithmetic right shift; SUB is never produced there.
    function automatic alu_ctrl_e decode(input logic [1:0] alu_op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic enable_m);
        alu_ctrl_e op;
        case (alu_op)
            ALUOP_ADDR:   op = ALU_ADD;
            ALUOP_BRANCH: op = ALU_SUB;
            ALUOP_ITYPE:  op = base_op(f3, f7[5] && (f3 == 3'b101));
            default: begin
                if (f7 == F7_BASE)
                    op = base_op(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
                    op = base_op(f3, 1'b1);
                else if (f7 == F7_MULDIV && enable_m)
                    op = muldiv_op(f3);
                else
                    op = ALU_ILL;
            end
        endcase
        return op;
    endfunction

    function automatic logic is_muldiv(input alu_ctrl_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes.
// start loads operands; done flags the cycle whose closing edge performs the last step.
module alu_muldiv_iter
    import alu_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  alu_ctrl_e       op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [XLEN-1:0] a_q, a_d;
    alu_ctrl_e       op_q, op_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            b_zero_q, b_zero_d;

    logic            signed_a, signed_b, is_div;
    logic [XLEN:0]   mul_sum, div_shift, div_trial;
    logic [2*XLEN-1:0] product, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign signed_a = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    assign signed_b = op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    assign is_div   = op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    // hi:lo is the running product (multiplier consumed from lo) or remainder:quotient.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, m_q};

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        a_d      = a_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            hi_d     = '0;
            op_d     = op;
            a_d      = op_a;
            a_neg_d  = signed_a && op_a[XLEN-1];
            b_neg_d  = signed_b && op_b[XLEN-1];
            b_zero_d = (op_b == '0);
            lo_d     = a_neg_d ? -op_a : op_a;
            m_d      = b_neg_d ? -op_b : op_b;
        end else if (busy_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1))
                busy_d = 1'b0;
            if (is_div) begin
                if (!div_trial[XLEN]) begin
                    hi_d = div_trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_d = mul_sum[XLEN:1];
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            a_q      <= '0;
            op_q     <= ALU_ADD;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            a_q      <= a_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
        end
    end

    assign done     = busy_q && (cnt_q == CW'(XLEN - 1));
    assign product  = {hi_q, lo_q};
    assign prod_fix = (a_neg_q ^ b_neg_q) ? -product : product;
    assign quo_fix  = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
    assign rem_fix  = a_neg_q ? -hi_q : hi_q;

    always_comb begin
        result = '0;
        case (op_q)
            ALU_MUL:                          result = prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                result = b_zero_q ? '1 : quo_fix;
            ALU_REM, ALU_REMU:                result = b_zero_q ? a_q : rem_fix;
            default:                          result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I/M execute stage: decode, single-cycle ALU, iterative mul/div FSM and
// a valid/ready output register feeding writeback.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  logic [1:0]      aluOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    exec_state_e     state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    alu_ctrl_e       dec_op;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic            md_start, md_done;
    logic [XLEN-1:0] md_result;

    assign dec_op  = decode(aluOp, funct3, funct7, ENABLE_M);
    assign shamt   = opB[SHW-1:0];
    assign inReady = (state_q == ST_IDLE) && (!out_valid_q || outReady);
    assign accept  = inValid && inReady;

    always_comb begin
        alu_res = '0;
        case (dec_op)
            ALU_ADD:  alu_res = opA + opB;
            ALU_SUB:  alu_res = opA - opB;
            ALU_SLL:  alu_res = opA << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opA < opB)};
            ALU_XOR:  alu_res = opA ^ opB;
            ALU_SRL:  alu_res = opA >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(opA) >>> shamt);
            ALU_OR:   alu_res = opA | opB;
            ALU_AND:  alu_res = opA & opB;
            default:  alu_res = '0;
        endcase
    end

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (dec_op),
        .op_a   (opA),
        .op_b   (opB),
        .done   (md_done),
        .result (md_result)
    );

    // A drain and a fresh load can share one edge, so valid clears first and is then re-set.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        illegal_d   = illegal_q;
        md_start    = 1'b0;
        if (out_valid_q && outReady)
            out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_muldiv(dec_op)) begin
                        md_start = 1'b1;
                        state_d  = ST_CALC;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        illegal_d   = (dec_op == ALU_ILL);
                    end
                end
            end
            ST_CALC: begin
                if (md_done)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid_d = 1'b1;
                result_d    = md_result;
                illegal_d   = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
        end
    end

    assign outValid = out_valid_q;
    assign result   = result_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expectations,
// a monitor pops and compares on every output handshake.
module tb_alu_exec_unit;
    localparam int XLEN = 32;
    localparam int MLAT = XLEN + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b1;
    logic [1:0]  aluOp = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic [6:0]  funct7 = 7'h00;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        inReady, outValid, illegal;
    logic [31:0] result;
    logic        nm_inReady, nm_outValid, nm_illegal;
    logic [31:0] nm_result;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          id;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;

    localparam int NB = 12;
    localparam int NM = 12;

    vec_t base_tab [NB] = '{
        '{2'b00, 3'b000, 7'h00, 32'd10,         32'd20,         32'd30,         1'b0},
        '{2'b01, 3'b000, 7'h00, 32'd10,         32'd3,          32'd7,          1'b0},
        '{2'b10, 3'b010, 7'h00, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0},
        '{2'b10, 3'b011, 7'h00, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0},
        '{2'b11, 3'b001, 7'h00, 32'd1,          32'd33,         32'd2,          1'b0},
        '{2'b10, 3'b100, 7'h00, 32'hF0F0F0F0,   32'h0FF00FF0,   32'hFF00FF00,   1'b0},
        '{2'b10, 3'b110, 7'h00, 32'hF0F0F0F0,   32'h0FF00FF0,   32'hFFF0FFF0,   1'b0},
        '{2'b10, 3'b111, 7'h00, 32'hF0F0F0F0,   32'h0FF00FF0,   32'h00F000F0,   1'b0},
        '{2'b10, 3'b101, 7'h00, 32'h80000000,   32'd4,          32'h08000000,   1'b0},
        '{2'b10, 3'b101, 7'h20, 32'h80000000,   32'd4,          32'hF8000000,   1'b0},
        '{2'b10, 3'b000, 7'h02, 32'd5,          32'd7,          32'd0,          1'b1},
        '{2'b10, 3'b001, 7'h20, 32'd5,          32'd7,          32'd0,          1'b1}
    };

    vec_t m_tab [NM] = '{
        '{2'b10, 3'b001, 7'h01, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   1'b0},
        '{2'b10, 3'b100, 7'h01, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0},
        '{2'b10, 3'b110, 7'h01, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1'b0},
        '{2'b10, 3'b101, 7'h01, 32'h00001234,   32'd0,          32'hFFFFFFFF,   1'b0},
        '{2'b10, 3'b111, 7'h01, 32'd9,          32'd0,          32'd9,          1'b0},
        '{2'b10, 3'b000, 7'h01, 32'd7,          32'hFFFFFFFD,   32'hFFFFFFEB,   1'b0},
        '{2'b10, 3'b100, 7'h01, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0},
        '{2'b10, 3'b110, 7'h01, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0},
        '{2'b10, 3'b011, 7'h01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0},
        '{2'b10, 3'b010, 7'h01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0},
        '{2'b10, 3'b100, 7'h01, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1'b0},
        '{2'b10, 3'b110, 7'h01, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1'b0}
    };

    alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .opA(opA), .opB(opB),
        .outValid(outValid), .outReady(outReady), .result(result), .illegal(illegal)
    );

    alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(nm_inReady),
        .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .opA(opA), .opB(opB),
        .outValid(nm_outValid), .outReady(1'b1), .result(nm_result), .illegal(nm_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && outValid && outReady) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_output: got result 0x%08h illegal %0b, expected no output",
                         result, illegal);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("txn%0d_result", mon_e.id), result, mon_e.res);
                check($sformatf("txn%0d_illegal", mon_e.id), 32'(illegal), 32'(mon_e.ill));
                $display("[TB] txn %0d result=0x%08h illegal=%0b (want 0x%08h/%0b)",
                         mon_e.id, result, illegal, mon_e.res, mon_e.ill);
            end
        end
    end

    task automatic send(input int id, input vec_t v, input bit push, output int waits);
        exp_t e;
        bit   acc;
        aluOp   = v.op;
        funct3  = v.f3;
        funct7  = v.f7;
        opA     = v.a;
        opB     = v.b;
        inValid = 1'b1;
        acc     = 1'b0;
        waits   = 0;
        if (push) begin
            e.res = v.res;
            e.ill = v.ill;
            e.id  = id;
            sb_q.push_back(e);
        end
        while (!acc && waits < 200) begin
            @(negedge clk);
            waits++;
            if (inReady) acc = 1'b1;
        end
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout txn%0d: got no inReady in %0d cycles, expected acceptance", id, waits);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Counts edges after the accepting edge until outValid shows.
    task automatic wait_out(input string name, input int exp_lat, input bit chk_busy);
        int lat;
        bit busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        while (!outValid && lat < 100) begin
            if (inReady) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (chk_busy) check({name, "_inReady_low"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected $finish");
        $fatal(1);
    end

    initial begin
        int   w;
        int   id;
        vec_t v;
        id = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outValid", 32'(outValid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_inReady", 32'(inReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type SUB, I-type SRAI and I-type with funct7=0100000 on funct3=000 (stays ADD)
        v = '{2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0};
        send(++id, v, 1'b1, w);
        wait_out("sub", 0, 1'b0);
        v = '{2'b11, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'hF8000000, 1'b0};
        send(++id, v, 1'b1, w);
        wait_out("srai", 0, 1'b0);
        v = '{2'b11, 3'b000, 7'h20, 32'h80000000, 32'd4, 32'h80000004, 1'b0};
        send(++id, v, 1'b1, w);
        wait_out("addi_alt", 0, 1'b0);

        for (int i = 0; i < NM; i++) begin
            send(++id, m_tab[i], 1'b1, w);
            wait_out($sformatf("mop%0d", i), MLAT, 1'b1);
        end

        // Back-to-back base ops: each must be accepted on the very next edge.
        for (int i = 0; i < NB; i++) begin
            send(++id, base_tab[i], 1'b1, w);
            check($sformatf("throughput%0d", i), 32'(w), 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;

        // ENABLE_M=0 instance must flag an M encoding as illegal with zero result.
        v = '{2'b10, 3'b000, 7'h01, 32'd6, 32'd7, 32'd42, 1'b0};
        send(++id, v, 1'b1, w);
        check("nm_outValid", 32'(nm_outValid), 32'd1);
        check("nm_illegal", 32'(nm_illegal), 32'd1);
        check("nm_result", nm_result, 32'd0);
        wait_out("mul_m", MLAT, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: result held stable, inReady low, then drain + new accept together.
        outReady = 1'b0;
        v = '{2'b00, 3'b000, 7'h00, 32'd3, 32'd4, 32'd7, 1'b0};
        send(++id, v, 1'b1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_result%0d", i), result, 32'd7);
            check($sformatf("bp_inReady%0d", i), 32'(inReady), 32'd0);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        v = '{2'b00, 3'b000, 7'h00, 32'd100, 32'd23, 32'd123, 1'b0};
        send(++id, v, 1'b1, w);
        check("bp_no_bubble", 32'(w), 32'd1);
        check("bp_next_result", result, 32'd123);
        wait_out("bp_next", 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Reset during DIVU iteration 10: nothing may ever come out.
        v = '{2'b10, 3'b101, 7'h01, 32'd100, 32'd3, 32'd33, 1'b0};
        send(++id, v, 1'b0, w);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_inReady", 32'(inReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_inReady", 32'(inReady), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("rst_no_output", 32'(outValid), 32'd0);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
